// File: rtl/array_ctrl.sv
// Array access controller: element load/store, newarray and arraylength over a
// one-access-at-a-time trigger/done memory port. Build option: ARRAY_ZERO_FILL_EN.
module array_ctrl #(
    parameter int ARR_SIZE = 1024
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        op_valid,
    output logic                        op_ready,
    input  logic [1:0]                  op_code,
    input  logic [31:0]                 arrref,
    input  logic [31:0]                 index,
    input  logic [31:0]                 value,
    output logic                        res_valid,
    output logic [31:0]                 res_data,
    output logic [1:0]                  res_exc,
    output logic                        mem_trigger,
    output logic                        mem_write,
    output logic [$clog2(ARR_SIZE)-1:0] mem_addr,
    output logic [31:0]                 mem_wdata,
    input  logic [31:0]                 mem_rdata,
    input  logic                        mem_done
);

    localparam int ADDR = $clog2(ARR_SIZE);

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_STORE = 2'b01;
    localparam logic [1:0] OP_NEW   = 2'b10;
    localparam logic [1:0] OP_LEN   = 2'b11;

    localparam logic [1:0] EXC_OK    = 2'b00;
    localparam logic [1:0] EXC_NULL  = 2'b01;
    localparam logic [1:0] EXC_OOB   = 2'b10;
    localparam logic [1:0] EXC_ALLOC = 2'b11;

    typedef enum logic [3:0] {
        IDLE,
        HDR,
        HDR_WAIT,
        ELEM,
        ELEM_WAIT,
        ALLOC,
        ALLOC_WAIT,
        RESP
`ifdef ARRAY_ZERO_FILL_EN
        ,
        ALLOC_ZERO,
        ALLOC_ZERO_WAIT
`endif
    } state_t;

    state_t           r_state;
    state_t           w_state_next;

    logic [1:0]       r_op;
    logic [31:0]      r_ref;
    logic [31:0]      r_index;
    logic [31:0]      r_value;
    logic [31:0]      r_len;
    logic [31:0]      w_len_next;
    logic [31:0]      r_free_ptr;
    logic [31:0]      w_free_ptr_next;
    logic             r_pend;

    logic             r_op_ready;
    logic             r_res_valid;
    logic [31:0]      r_res_data;
    logic [31:0]      w_res_data_next;
    logic [1:0]       r_res_exc;
    logic [1:0]       w_res_exc_next;
    logic             r_mem_trigger;
    logic             w_mem_trigger_next;
    logic             r_mem_write;
    logic             w_mem_write_next;
    logic [ADDR-1:0]  r_mem_addr;
    logic [ADDR-1:0]  w_mem_addr_next;
    logic [31:0]      r_mem_wdata;
    logic [31:0]      w_mem_wdata_next;

    logic             w_accept;
    logic             w_done;
    logic             w_commit;
    logic [ADDR-1:0]  w_elem_addr;
    logic [32:0]      w_alloc_end;

`ifdef ARRAY_ZERO_FILL_EN
    logic [ADDR-1:0]  r_zero_addr;
    logic [ADDR-1:0]  w_zero_addr_next;
    logic [ADDR-1:0]  w_zero_last;
    assign w_zero_last = ADDR'(r_free_ptr + r_index);
`endif

    assign w_accept    = op_valid && r_op_ready;
    // A done is only meaningful while one of our own accesses is outstanding.
    assign w_done      = mem_done && r_pend;
    assign w_elem_addr = ADDR'(r_ref + 32'd1 + r_index);
    assign w_alloc_end = {1'b0, r_free_ptr} + {1'b0, r_index} + 33'd1;

    always_comb begin
        w_state_next       = r_state;
        w_mem_trigger_next = 1'b0;
        w_mem_write_next   = r_mem_write;
        w_mem_addr_next    = r_mem_addr;
        w_mem_wdata_next   = r_mem_wdata;
        w_res_data_next    = r_res_data;
        w_res_exc_next     = r_res_exc;
        w_len_next         = r_len;
        w_free_ptr_next    = r_free_ptr;
        w_commit           = 1'b0;
`ifdef ARRAY_ZERO_FILL_EN
        w_zero_addr_next   = r_zero_addr;
`endif
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_next = (op_code == OP_NEW) ? ALLOC : HDR;
                end
            end
            HDR: begin
                if (r_ref == 32'd0) begin
                    w_state_next    = RESP;
                    w_res_data_next = 32'd0;
                    w_res_exc_next  = EXC_NULL;
                end else begin
                    w_mem_trigger_next = 1'b1;
                    w_mem_write_next   = 1'b0;
                    w_mem_addr_next    = r_ref[ADDR-1:0];
                    w_state_next       = HDR_WAIT;
                end
            end
            HDR_WAIT: begin
                if (w_done) begin
                    w_len_next = mem_rdata;
                    if (r_op == OP_LEN) begin
                        w_state_next    = RESP;
                        w_res_data_next = mem_rdata;
                        w_res_exc_next  = EXC_OK;
                    end else begin
                        w_state_next = ELEM;
                    end
                end
            end
            ELEM: begin
                // Unsigned compare also rejects negative indices.
                if (r_index >= r_len) begin
                    w_state_next    = RESP;
                    w_res_data_next = 32'd0;
                    w_res_exc_next  = EXC_OOB;
                end else begin
                    w_mem_trigger_next = 1'b1;
                    w_mem_write_next   = (r_op == OP_STORE);
                    w_mem_addr_next    = w_elem_addr;
                    w_mem_wdata_next   = r_value;
                    w_state_next       = ELEM_WAIT;
                end
            end
            ELEM_WAIT: begin
                if (w_done) begin
                    w_state_next    = RESP;
                    w_res_exc_next  = EXC_OK;
                    w_res_data_next = (r_op == OP_LOAD) ? mem_rdata : 32'd0;
                end
            end
            ALLOC: begin
                if (r_index[31] || (w_alloc_end > 33'(ARR_SIZE))) begin
                    w_state_next    = RESP;
                    w_res_data_next = 32'd0;
                    w_res_exc_next  = EXC_ALLOC;
                end else begin
                    w_mem_trigger_next = 1'b1;
                    w_mem_write_next   = 1'b1;
                    w_mem_addr_next    = r_free_ptr[ADDR-1:0];
                    w_mem_wdata_next   = r_index;
                    w_state_next       = ALLOC_WAIT;
                end
            end
            ALLOC_WAIT: begin
                if (w_done) begin
`ifdef ARRAY_ZERO_FILL_EN
                    if (r_index == 32'd0) begin
                        w_commit = 1'b1;
                    end else begin
                        w_zero_addr_next = ADDR'(r_free_ptr + 32'd1);
                        w_state_next     = ALLOC_ZERO;
                    end
`else
                    w_commit = 1'b1;
`endif
                end
            end
`ifdef ARRAY_ZERO_FILL_EN
            ALLOC_ZERO: begin
                w_mem_trigger_next = 1'b1;
                w_mem_write_next   = 1'b1;
                w_mem_addr_next    = r_zero_addr;
                w_mem_wdata_next   = 32'd0;
                w_state_next       = ALLOC_ZERO_WAIT;
            end
            ALLOC_ZERO_WAIT: begin
                if (w_done) begin
                    if (r_zero_addr == w_zero_last) begin
                        w_commit = 1'b1;
                    end else begin
                        w_zero_addr_next = r_zero_addr + 1'b1;
                        w_state_next     = ALLOC_ZERO;
                    end
                end
            end
`endif
            RESP: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase

        // The free pointer only moves once the whole allocation has landed in memory.
        if (w_commit) begin
            w_state_next    = RESP;
            w_res_exc_next  = EXC_OK;
            w_res_data_next = r_free_ptr;
            w_free_ptr_next = r_free_ptr + r_index + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_op          <= OP_LOAD;
            r_ref         <= 32'd0;
            r_index       <= 32'd0;
            r_value       <= 32'd0;
            r_len         <= 32'd0;
            r_free_ptr    <= 32'd1;
            r_pend        <= 1'b0;
            r_op_ready    <= 1'b0;
            r_res_valid   <= 1'b0;
            r_res_data    <= 32'd0;
            r_res_exc     <= EXC_OK;
            r_mem_trigger <= 1'b0;
            r_mem_write   <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_wdata   <= 32'd0;
        end else begin
            r_state       <= w_state_next;
            r_len         <= w_len_next;
            r_free_ptr    <= w_free_ptr_next;
            r_op_ready    <= (w_state_next == IDLE);
            r_res_valid   <= (w_state_next == RESP);
            r_res_data    <= w_res_data_next;
            r_res_exc     <= w_res_exc_next;
            r_mem_trigger <= w_mem_trigger_next;
            r_mem_write   <= w_mem_write_next;
            r_mem_addr    <= w_mem_addr_next;
            r_mem_wdata   <= w_mem_wdata_next;
            if (w_mem_trigger_next) begin
                r_pend <= 1'b1;
            end else if (mem_done) begin
                r_pend <= 1'b0;
            end
            if (w_accept) begin
                r_op    <= op_code;
                r_ref   <= arrref;
                r_index <= index;
                r_value <= value;
            end
        end
    end

`ifdef ARRAY_ZERO_FILL_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_zero_addr <= '0;
        end else begin
            r_zero_addr <= w_zero_addr_next;
        end
    end
`endif

    assign op_ready    = r_op_ready;
    assign res_valid   = r_res_valid;
    assign res_data    = r_res_data;
    assign res_exc     = r_res_exc;
    assign mem_trigger = r_mem_trigger;
    assign mem_write   = r_mem_write;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;

endmodule

// File: tb/tb_array_ctrl.sv
// Directed bench for array_ctrl with a behavioural memory answering each trigger
// with done two cycles later.
module tb_array_ctrl;

    localparam int ARR_SIZE = 1024;
    localparam int AW       = $clog2(ARR_SIZE);

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_STORE = 2'b01;
    localparam logic [1:0] OP_NEW   = 2'b10;
    localparam logic [1:0] OP_LEN   = 2'b11;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          op_valid = 1'b0;
    logic [1:0]    op_code = 2'b00;
    logic [31:0]   arrref = 32'd0;
    logic [31:0]   index = 32'd0;
    logic [31:0]   value = 32'd0;
    wire           op_ready;
    wire           res_valid;
    wire [31:0]    res_data;
    wire [1:0]     res_exc;
    wire           mem_trigger;
    wire           mem_write;
    wire [AW-1:0]  mem_addr;
    wire [31:0]    mem_wdata;
    logic [31:0]   mem_rdata;
    wire           mem_done;

    int vec_cnt = 0;
    int err_cnt = 0;

    bit [31:0]     mem [ARR_SIZE];
    logic [1:0]    done_sh = 2'b00;
    int            trig_cnt = 0;
    logic [AW-1:0] last_addr;
    logic          last_write;

    array_ctrl #(.ARR_SIZE(ARR_SIZE)) dut (
        .clk         (clk),
        .rst         (rst),
        .op_valid    (op_valid),
        .op_ready    (op_ready),
        .op_code     (op_code),
        .arrref      (arrref),
        .index       (index),
        .value       (value),
        .res_valid   (res_valid),
        .res_data    (res_data),
        .res_exc     (res_exc),
        .mem_trigger (mem_trigger),
        .mem_write   (mem_write),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_done    (mem_done)
    );

    always #5 clk = ~clk;

    // Memory model ignores rst so an in-flight done still arrives after a reset.
    always @(posedge clk) begin
        done_sh <= {done_sh[0], mem_trigger};
        if (mem_trigger) begin
            trig_cnt   <= trig_cnt + 1;
            last_addr  <= mem_addr;
            last_write <= mem_write;
            if (mem_write) begin
                mem[mem_addr] <= mem_wdata;
            end else begin
                mem_rdata <= mem[mem_addr];
            end
        end
    end
    assign mem_done = done_sh[1];

    task automatic do_op(input logic [1:0] code, input logic [31:0] r, input logic [31:0] idx,
                         input logic [31:0] val, input int budget,
                         output logic [31:0] data, output logic [1:0] exc, output int lat);
        int w;
        w = 0;
        while (!op_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        op_code  = code;
        arrref   = r;
        index    = idx;
        value    = val;
        op_valid = 1'b1;
        @(negedge clk);
        op_valid = 1'b0;
        lat = 1;
        while (!res_valid && lat < budget) begin
            @(negedge clk);
            lat++;
        end
        vec_cnt++;
        if (!res_valid) begin
            $display("FAIL op_timeout: op=%0d ref=%0d idx=%0d got no res_valid after %0d cycles, required a result",
                     code, r, idx, lat);
            err_cnt++;
        end
        data = res_data;
        exc  = res_exc;
        $display("op=%0d ref=%0d idx=0x%08h val=0x%08h -> data=0x%08h exc=%0d lat=%0d",
                 code, r, idx, val, data, exc, lat);
    endtask

    task automatic pulse_rst();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        vec_cnt++;
        if (op_ready !== 1'b0) begin
            $display("FAIL rst_op_ready: got %b want 0", op_ready);
            err_cnt++;
        end
        vec_cnt++;
        if ({res_valid, mem_trigger, mem_write, mem_addr, mem_wdata, res_data, res_exc} !== '0) begin
            $display("FAIL rst_outputs: got rv=%b trig=%b wr=%b addr=%0d wd=%h rd=%h exc=%0d want all 0",
                     res_valid, mem_trigger, mem_write, mem_addr, mem_wdata, res_data, res_exc);
            err_cnt++;
        end
        rst = 1'b0;
        @(negedge clk);
        vec_cnt++;
        if (op_ready !== 1'b1) begin
            $display("FAIL rst_ready_after: got %b want 1", op_ready);
            err_cnt++;
        end
        $display("reset: op_ready=%b", op_ready);
    endtask

    task automatic test_newarray();
        logic [31:0] d;
        logic [1:0]  e;
        int          l;
        do_op(OP_NEW, 32'd0, 32'd4, 32'd0, 100, d, e, l);
        vec_cnt++;
        if (e !== 2'd0 || d !== 32'd1) begin
            $display("FAIL new4: got exc=%0d data=%0d want exc=0 data=1", e, d);
            err_cnt++;
        end
        vec_cnt++;
        if (mem[1] !== 32'd4) begin
            $display("FAIL new4_hdr: got mem[1]=%0d want 4", mem[1]);
            err_cnt++;
        end
        do_op(OP_NEW, 32'd0, 32'd2, 32'd0, 100, d, e, l);
        vec_cnt++;
        if (e !== 2'd0 || d !== 32'd6) begin
            $display("FAIL new2: got exc=%0d data=%0d want exc=0 data=6", e, d);
            err_cnt++;
        end
        vec_cnt++;
        if (mem[6] !== 32'd2) begin
            $display("FAIL new2_hdr: got mem[6]=%0d want 2", mem[6]);
            err_cnt++;
        end
    endtask

    task automatic test_store_load();
        logic [31:0] d;
        logic [1:0]  e;
        int          l;
        int          t0;
        t0 = trig_cnt;
        do_op(OP_STORE, 32'd1, 32'd2, 32'hDEADBEEF, 100, d, e, l);
        vec_cnt++;
        if (e !== 2'd0 || d !== 32'd0) begin
            $display("FAIL store: got exc=%0d data=%h want exc=0 data=0", e, d);
            err_cnt++;
        end
        vec_cnt++;
        if (last_addr !== 10'd4 || last_write !== 1'b1 || trig_cnt - t0 != 2) begin
            $display("FAIL store_access: got addr=%0d wr=%b trigs=%0d want addr=4 wr=1 trigs=2",
                     last_addr, last_write, trig_cnt - t0);
            err_cnt++;
        end
        vec_cnt++;
        if (mem[4] !== 32'hDEADBEEF) begin
            $display("FAIL store_mem: got mem[4]=%h want deadbeef", mem[4]);
            err_cnt++;
        end
        do_op(OP_LOAD, 32'd1, 32'd2, 32'd0, 100, d, e, l);
        vec_cnt++;
        if (e !== 2'd0 || d !== 32'hDEADBEEF) begin
            $display("FAIL load: got exc=%0d data=%h want exc=0 data=deadbeef", e, d);
            err_cnt++;
        end
        vec_cnt++;
        if (last_addr !== 10'd4 || last_write !== 1'b0) begin
            $display("FAIL load_access: got addr=%0d wr=%b want addr=4 wr=0", last_addr, last_write);
            err_cnt++;
        end
    endtask

    task automatic test_bounds();
        logic [31:0] d;
        logic [1:0]  e;
        int          l;
        int          t0;
        t0 = trig_cnt;
        do_op(OP_LOAD, 32'd1, 32'd4, 32'd0, 100, d, e, l);
        vec_cnt++;
        if (e !== 2'd2 || trig_cnt - t0 != 1) begin
            $display("FAIL oob_idx4: got exc=%0d trigs=%0d want exc=2 trigs=1", e, trig_cnt - t0);
            err_cnt++;
        end
        t0 = trig_cnt;
        do_op(OP_LOAD, 32'd1, 32'hFFFFFFFF, 32'd0, 100, d, e, l);
        vec_cnt++;
        if (e !== 2'd2 || trig_cnt - t0 != 1) begin
            $display("FAIL oob_neg: got exc=%0d trigs=%0d want exc=2 trigs=1", e, trig_cnt - t0);
            err_cnt++;
        end
        do_op(OP_STORE, 32'd1, 32'd4, 32'h12345678, 100, d, e, l);
        vec_cnt++;
        if (e !== 2'd2 || mem[6] !== 32'd2) begin
            $display("FAIL oob_store: got exc=%0d mem[6]=%h want exc=2 mem[6]=2", e, mem[6]);
            err_cnt++;
        end
        do_op(OP_STORE, 32'd1, 32'd3, 32'h0BADF00D, 100, d, e, l);
        vec_cnt++;
        if (e !== 2'd0 || mem[5] !== 32'h0BADF00D) begin
            $display("FAIL last_elem: got exc=%0d mem[5]=%h want exc=0 mem[5]=0badf00d", e, mem[5]);
            err_cnt++;
        end
    endtask

    task automatic test_null_len();
        logic [31:0] d;
        logic [1:0]  e;
        int          l;
        int          t0;
        t0 = trig_cnt;
        do_op(OP_LOAD, 32'd0, 32'd0, 32'd0, 100, d, e, l);
        vec_cnt++;
        if (e !== 2'd1 || l != 2 || trig_cnt - t0 != 0) begin
            $display("FAIL null_load: got exc=%0d lat=%0d trigs=%0d want exc=1 lat=2 trigs=0",
                     e, l, trig_cnt - t0);
            err_cnt++;
        end
        do_op(OP_LEN, 32'd1, 32'd0, 32'd0, 100, d, e, l);
        vec_cnt++;
        if (e !== 2'd0 || d !== 32'd4) begin
            $display("FAIL arraylen: got exc=%0d data=%0d want exc=0 data=4", e, d);
            err_cnt++;
        end
        @(negedge clk);
        vec_cnt++;
        if (res_valid !== 1'b0 || op_ready !== 1'b1 || res_data !== 32'd4) begin
            $display("FAIL resp_pulse: got rv=%b ready=%b data=%0d want rv=0 ready=1 data=4",
                     res_valid, op_ready, res_data);
            err_cnt++;
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        logic [1:0]  e;
        int          l;
        int          w;
        int          rv;
        pulse_rst();
        do_op(OP_NEW, 32'd0, 32'd4, 32'd0, 200, d, e, l);
        op_code  = OP_STORE;
        arrref   = 32'd1;
        index    = 32'd0;
        value    = 32'h55AA55AA;
        op_valid = 1'b1;
        @(negedge clk);
        op_valid = 1'b0;
        w = 0;
        while (!(mem_trigger && mem_write) && w < 50) begin
            @(negedge clk);
            w++;
        end
        rst = 1'b1;
        rv = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (res_valid) rv++;
            if (i == 1) rst = 1'b0;
        end
        vec_cnt++;
        if (rv != 0 || op_ready !== 1'b1) begin
            $display("FAIL rst_mid: got res_valid_cycles=%0d ready=%b want 0 and ready=1", rv, op_ready);
            err_cnt++;
        end
        do_op(OP_NEW, 32'd0, 32'd2, 32'd0, 200, d, e, l);
        vec_cnt++;
        if (e !== 2'd0 || d !== 32'd1) begin
            $display("FAIL rst_mid_new: got exc=%0d data=%0d want exc=0 data=1", e, d);
            err_cnt++;
        end
    endtask

    task automatic test_zero_fill();
        logic [31:0] d;
        logic [1:0]  e;
        int          l;
        logic [31:0] want;
        pulse_rst();
        do_op(OP_NEW, 32'd0, 32'd3, 32'd0, 200, d, e, l);
        for (int i = 0; i < 3; i++) begin
            do_op(OP_STORE, 32'd1, i, 32'd11 * (i + 1), 100, d, e, l);
        end
        pulse_rst();
        do_op(OP_NEW, 32'd0, 32'd3, 32'd0, 200, d, e, l);
        vec_cnt++;
        if (e !== 2'd0 || d !== 32'd1 || mem[1] !== 32'd3) begin
            $display("FAIL zf_new: got exc=%0d data=%0d mem[1]=%0d want exc=0 data=1 mem[1]=3", e, d, mem[1]);
            err_cnt++;
        end
        for (int i = 0; i < 3; i++) begin
`ifdef ARRAY_ZERO_FILL_EN
            want = 32'd0;
`else
            want = 32'd11 * (i + 1);
`endif
            vec_cnt++;
            if (mem[2 + i] !== want) begin
                $display("FAIL zf_word%0d: got %0d want %0d", 2 + i, mem[2 + i], want);
                err_cnt++;
            end
        end
        do_op(OP_LOAD, 32'd1, 32'd1, 32'd0, 100, d, e, l);
        vec_cnt++;
        if (e !== 2'd0 || d !== mem[3]) begin
            $display("FAIL zf_load: got exc=%0d data=%0d want exc=0 data=%0d", e, d, mem[3]);
            err_cnt++;
        end
    endtask

    task automatic test_alloc_limit();
        logic [31:0] d;
        logic [1:0]  e;
        int          l;
        pulse_rst();
        do_op(OP_NEW, 32'd0, 32'hFFFFFFFF, 32'd0, 100, d, e, l);
        vec_cnt++;
        if (e !== 2'd3) begin
            $display("FAIL alloc_neg: got exc=%0d want 3", e);
            err_cnt++;
        end
        do_op(OP_NEW, 32'd0, ARR_SIZE - 1, 32'd0, 100, d, e, l);
        vec_cnt++;
        if (e !== 2'd3) begin
            $display("FAIL alloc_over: got exc=%0d want 3", e);
            err_cnt++;
        end
        do_op(OP_NEW, 32'd0, ARR_SIZE - 2, 32'd0, 8000, d, e, l);
        vec_cnt++;
        if (e !== 2'd0 || d !== 32'd1) begin
            $display("FAIL alloc_fit: got exc=%0d data=%0d want exc=0 data=1", e, d);
            err_cnt++;
        end
        do_op(OP_NEW, 32'd0, 32'd0, 32'd0, 100, d, e, l);
        vec_cnt++;
        if (e !== 2'd3) begin
            $display("FAIL alloc_full: got exc=%0d want 3", e);
            err_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_newarray();
        test_store_load();
        test_bounds();
        test_null_len();
        test_reset_mid();
        test_zero_fill();
        test_alloc_limit();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
